// File: rtl/instruction_decode_stage.sv
// IF/ID pipeline stage: two-entry (main + skid) buffer with registered fetch-side ready and field split.
// Optional illegal-encoding flag enabled by defining DECODE_ILLEGAL_CHECK_EN.
module instruction_decode_stage #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0
) (
    input  logic            i_Clock,
    input  logic            i_Reset_N,
    input  logic            i_Instr_Valid,
    output logic            o_Instr_Ready,
    input  logic [31:0]     i_Instruction,
    input  logic [XLEN-1:0] i_Pc,
    input  logic            i_Flush,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [31:0]     o_Instruction,
    output logic [XLEN-1:0] o_Pc,
    output logic [6:0]      o_Op_Code,
    output logic [4:0]      o_Rd,
    output logic [2:0]      o_Funct3,
    output logic [4:0]      o_Rs1,
    output logic [4:0]      o_Rs2,
    output logic            o_Funct7_Bit_5,
    output logic            o_Illegal
);

    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t main_q, skid_q;
    logic   main_valid_q, skid_valid_q, instr_ready_q;

    logic   main_valid_n, skid_valid_n;
    logic   main_load_in, main_load_skid, skid_load;
    logic   up_beat, dn_beat;

    assign up_beat = i_Instr_Valid & instr_ready_q;
    assign dn_beat = main_valid_q & i_Ready;

    // Next-state for occupancy plus load strobes for the data registers
    always_comb begin
        main_valid_n   = main_valid_q;
        skid_valid_n   = skid_valid_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (i_Flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid_q) begin
            if (up_beat) begin
                main_valid_n = 1'b1;
                main_load_in = 1'b1;
            end
        end else if (dn_beat) begin
            if (skid_valid_q) begin
                main_load_skid = 1'b1;
                skid_valid_n   = 1'b0;
            end else if (up_beat) begin
                main_load_in = 1'b1;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (up_beat) begin
            skid_load    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            main_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            main_valid_q  <= main_valid_n;
            skid_valid_q  <= skid_valid_n;
            instr_ready_q <= ~skid_valid_n;
        end
    end

    // Data registers only move on their load strobes so held outputs stay stable
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            main_q <= '{instr: '0, pc: RESET_PC};
            skid_q <= '{instr: '0, pc: RESET_PC};
        end else begin
            if (main_load_in) begin
                main_q <= '{instr: i_Instruction, pc: i_Pc};
            end else if (main_load_skid) begin
                main_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= '{instr: i_Instruction, pc: i_Pc};
            end
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic in_illegal;
    logic main_ill_q, skid_ill_q;

    // Only the base RV32I major opcodes are supported by control_unit
    always_comb begin
        in_illegal = (i_Instruction[1:0] != 2'b11) ||
                     !(i_Instruction[6:0] inside {7'b0110011, 7'b0110111, 7'b0010111,
                                                  7'b1101111, 7'b0010011, 7'b1100111,
                                                  7'b0000011, 7'b0100011, 7'b1100011});
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            main_ill_q <= 1'b0;
            skid_ill_q <= 1'b0;
        end else begin
            if (!main_valid_n) begin
                main_ill_q <= 1'b0;
            end else if (main_load_in) begin
                main_ill_q <= in_illegal;
            end else if (main_load_skid) begin
                main_ill_q <= skid_ill_q;
            end
            if (skid_load) begin
                skid_ill_q <= in_illegal;
            end
        end
    end

    assign o_Illegal = main_ill_q;
`else
    assign o_Illegal = 1'b0;
`endif

    assign o_Instr_Ready  = instr_ready_q;
    assign o_Valid        = main_valid_q;
    assign o_Instruction  = main_q.instr;
    assign o_Pc           = main_q.pc;
    assign o_Op_Code      = main_q.instr[6:0];
    assign o_Rd           = main_q.instr[11:7];
    assign o_Funct3       = main_q.instr[14:12];
    assign o_Rs1          = main_q.instr[19:15];
    assign o_Rs2          = main_q.instr[24:20];
    assign o_Funct7_Bit_5 = main_q.instr[30];

endmodule
